program_counter_stack: RTL and testbench
========================================

Name: program_counter_stack

Overview:
Parametrised program counter for the RISC CPU core, with a hardware return-address stack. It is clocked from the core clock and uses a per-cycle advance enable instead of the older strobe-as-clock style. Supported updates: increment, absolute jump, PC-relative branch, call and return. Stack overflow and underflow are detected and reported, not silently corrupted.

Parameters:
ADDR_W, 13, PC/address width in bits (>= 2).
STACK_DEPTH, 4, return-stack entries (>= 1).
RESET_ADDR, 0, PC value after reset (ADDR_W bits).
DEPTH_W, $clog2(STACK_DEPTH+1), width of the depth count (derived; not overridden).

Ports:
clk  in  1  core clock, rising-edge.
rst_n  in  1  synchronous, active-low reset.
en  in  1  advance enable; op is acted on only when en=1.
op  in  3  000 INC, 001 JUMP, 010 BRANCH, 011 CALL, 100 RET, 101-111 reserved (NOP).
target  in  ADDR_W  absolute address for JUMP/CALL; two's-complement offset for BRANCH.
pc_addr  out  ADDR_W  current PC (registered).
depth  out  DEPTH_W  number of valid stack entries (registered).
stack_full  out  1  depth == STACK_DEPTH.
stack_empty  out  1  depth == 0.
err  out  1  one-cycle pulse on overflow or underflow.

Behaviour:
- All state updates on rising clk. Priority: rst_n=0, then en=0, then op decode.
- Reset (rst_n=0 at an edge): pc_addr=RESET_ADDR, depth=0, err=0. Reset during any op discards that op. Stack storage is not reset and holds no meaning until pushed.
- en=0: pc_addr and depth hold, err=0. op and target are ignored.
- Latency: an op sampled at edge N appears on pc_addr, depth and err after edge N. Nothing is combinational from the inputs.
- All PC arithmetic is modulo 2^ADDR_W:
  - INC: pc <= pc+1; the all-ones value wraps to 0.
  - JUMP: pc <= target.
  - BRANCH: pc <= pc + target, with target sign-interpreted; the result wraps.
- CALL, not full: stack[depth] <= pc+1 (wrapped); pc <= target; depth <= depth+1.
- CALL, full (overflow): pc, depth and stack unchanged; err=1 for one cycle.
- RET, not empty: pc <= stack[depth-1]; depth <= depth-1.
- RET, empty (underflow): pc and depth unchanged; err=1 for one cycle.
- Reserved ops: NOP (hold), err=0.
- err is 0 in every cycle that does not follow an overflow or underflow.
- Back-to-back faults give err=1 on consecutive cycles.
- The stack is strictly LIFO. When STACK_DEPTH=1, a single CALL sets stack_full.
- stack_full and stack_empty are decoded from the registered depth only. They are mutually exclusive for STACK_DEPTH >= 1.

Test Plan:
1. Reset: rst_n=0 for 2 clocks with en=1, op=CALL -> pc_addr=0x0000, depth=0, stack_empty=1, err=0. Then push 2 entries and assert rst_n=0 for one edge -> depth=0, pc_addr=0x0000.
2. Wrap: JUMP target=0x1FFF, then INC -> pc_addr=0x0000. BRANCH from pc=0x0010 with target=0x1FFC -> 0x000C. BRANCH from pc=0x0002 with target=0x1FFC -> 0x1FFE.
3. Nested calls: pc=0x0100, CALL 0x0200 -> pc=0x0200, depth=1. CALL 0x0300 -> depth=2. RET -> pc=0x0201. RET -> pc=0x0101, stack_empty=1, err never set.
4. Overflow: 4 CALLs to 0x0A00, 0x0B00, 0x0C00, 0x0D00 -> stack_full=1. 5th CALL 0x0E00 -> err=1 for exactly one cycle, pc stays 0x0D00, depth=4. 4 RETs then return 0x0C01, 0x0B01, 0x0A01, then the original pc+1, in that order.
5. Underflow: with depth=0, RET twice -> err=1 on both cycles, pc unchanged, depth=0. A following INC -> err=0, pc+1.
6. Enable gating and reserved ops: en=0 with op=JUMP, target=0x0555 for 3 cycles -> pc and depth hold. en=1 with op=111 -> pc holds, err=0.

Source files
------------

// File: rtl/program_counter_stack.sv
// Program counter with a hardware return-address stack.
// Supports increment, jump, PC-relative branch, call and return, and flags stack overflow/underflow.
module program_counter_stack #(
    parameter int                 ADDR_W      = 13,
    parameter int                 STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  RESET_ADDR  = '0,
    localparam int                DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [2:0]         op,
    input  logic [ADDR_W-1:0]  target,
    output logic [ADDR_W-1:0]  pc_addr,
    output logic [DEPTH_W-1:0] depth,
    output logic               stack_full,
    output logic               stack_empty,
    output logic               err
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_INC    = 3'b000,
        OP_JUMP   = 3'b001,
        OP_BRANCH = 3'b010,
        OP_CALL   = 3'b011,
        OP_RET    = 3'b100
    } op_e;

    logic [ADDR_W-1:0]  r_pc;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_err;
    logic [ADDR_W-1:0]  r_stack [0:STACK_DEPTH-1];

    logic [ADDR_W-1:0]  w_pc_inc;
    logic [ADDR_W-1:0]  w_pc_next;
    logic [DEPTH_W-1:0] w_depth_next;
    logic [DEPTH_W-1:0] w_depth_dec;
    logic               w_err_next;
    logic               w_push;
    logic               w_full;
    logic               w_empty;

    assign w_pc_inc    = r_pc + ADDR_W'(1);
    assign w_depth_dec = r_depth - DEPTH_W'(1);
    assign w_full      = (r_depth == DEPTH_W'(STACK_DEPTH));
    assign w_empty     = (r_depth == '0);

    // Branch offset is two's complement; a plain same-width add gives the wrapped result.
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        w_pc_next    = r_pc;
        w_depth_next = r_depth;
        w_err_next   = 1'b0;
        w_push       = 1'b0;
        if (en) begin
            case (op_e'(op))
                OP_INC:    w_pc_next = w_pc_inc;
                OP_JUMP:   w_pc_next = target;
                OP_BRANCH: w_pc_next = r_pc + target;
                OP_CALL: begin
                    if (w_full) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_push       = 1'b1;
                        w_pc_next    = target;
                        w_depth_next = r_depth + DEPTH_W'(1);
                    end
                end
                OP_RET: begin
                    if (w_empty) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_pc_next    = r_stack[w_depth_dec[IDX_W-1:0]];
                        w_depth_next = w_depth_dec;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            r_pc    <= RESET_ADDR;
            r_depth <= '0;
            r_err   <= 1'b0;
        end else begin
            r_pc    <= w_pc_next;
            r_depth <= w_depth_next;
            r_err   <= w_err_next;
        end
    end

    // NOTE: stack storage has no reset; entries are only read below the valid depth.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_stack[r_depth[IDX_W-1:0]] <= w_pc_inc;
        end
    end

    assign pc_addr     = r_pc;
    assign depth       = r_depth;
    assign err         = r_err;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed self-checking bench for program_counter_stack (default parameters).
// Each task drives one scenario and compares outputs against hand-computed values.
module tb_program_counter_stack;

    localparam logic [2:0] OP_INC    = 3'b000;
    localparam logic [2:0] OP_JUMP   = 3'b001;
    localparam logic [2:0] OP_BRANCH = 3'b010;
    localparam logic [2:0] OP_CALL   = 3'b011;
    localparam logic [2:0] OP_RET    = 3'b100;
    localparam logic [2:0] OP_RSV7   = 3'b111;
    localparam logic [2:0] OP_RSV5   = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [2:0]  op;
    logic [12:0] target;
    logic [12:0] pc_addr;
    logic [2:0]  depth;
    logic        stack_full;
    logic        stack_empty;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    program_counter_stack dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .op          (op),
        .target      (target),
        .pc_addr     (pc_addr),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic step(input logic e, input logic [2:0] o, input logic [12:0] t);
        en = e; op = o; target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(1'b1, OP_CALL, 13'h0AAA);
        step(1'b1, OP_CALL, 13'h0AAA);
        n_checks++;
        if (pc_addr !== 13'h0000) begin
            $display("FAIL reset_pc: got %h expected %h", pc_addr, 13'h0000); n_errors++;
        end
        n_checks++;
        if (depth !== 3'd0 || stack_empty !== 1'b1 || stack_full !== 1'b0) begin
            $display("FAIL reset_depth: got depth=%0d empty=%b full=%b expected 0/1/0", depth, stack_empty, stack_full); n_errors++;
        end
        n_checks++;
        if (err !== 1'b0) begin
            $display("FAIL reset_err: got %b expected 0", err); n_errors++;
        end
        rst_n = 1'b1;
        step(1'b1, OP_CALL, 13'h0100);
        step(1'b1, OP_CALL, 13'h0200);
        n_checks++;
        if (depth !== 3'd2 || pc_addr !== 13'h0200) begin
            $display("FAIL reset_push2: got depth=%0d pc=%h expected 2/0200", depth, pc_addr); n_errors++;
        end
        rst_n = 1'b0;
        step(1'b1, OP_CALL, 13'h0300);
        rst_n = 1'b1;
        n_checks++;
        if (depth !== 3'd0 || pc_addr !== 13'h0000 || err !== 1'b0) begin
            $display("FAIL reset_midrun: got depth=%0d pc=%h err=%b expected 0/0000/0", depth, pc_addr, err); n_errors++;
        end
    endtask

    task automatic test_wrap;
        step(1'b1, OP_JUMP, 13'h1FFF);
        n_checks++;
        if (pc_addr !== 13'h1FFF) begin
            $display("FAIL wrap_jump: got %h expected %h", pc_addr, 13'h1FFF); n_errors++;
        end
        step(1'b1, OP_INC, 13'h0000);
        n_checks++;
        if (pc_addr !== 13'h0000 || err !== 1'b0) begin
            $display("FAIL wrap_inc: got pc=%h err=%b expected 0000/0", pc_addr, err); n_errors++;
        end
        step(1'b1, OP_JUMP, 13'h0010);
        step(1'b1, OP_BRANCH, 13'h1FFC);
        n_checks++;
        if (pc_addr !== 13'h000C) begin
            $display("FAIL branch_back: got %h expected %h", pc_addr, 13'h000C); n_errors++;
        end
        step(1'b1, OP_JUMP, 13'h0002);
        step(1'b1, OP_BRANCH, 13'h1FFC);
        n_checks++;
        if (pc_addr !== 13'h1FFE) begin
            $display("FAIL branch_wrap: got %h expected %h", pc_addr, 13'h1FFE); n_errors++;
        end
        step(1'b1, OP_BRANCH, 13'h0005);
        n_checks++;
        if (pc_addr !== 13'h0003) begin
            $display("FAIL branch_fwd_wrap: got %h expected %h", pc_addr, 13'h0003); n_errors++;
        end
    endtask

    task automatic test_nested_calls;
        logic err_seen;
        err_seen = 1'b0;
        step(1'b1, OP_JUMP, 13'h0100);
        step(1'b1, OP_CALL, 13'h0200);
        err_seen |= err;
        n_checks++;
        if (pc_addr !== 13'h0200 || depth !== 3'd1) begin
            $display("FAIL call1: got pc=%h depth=%0d expected 0200/1", pc_addr, depth); n_errors++;
        end
        step(1'b1, OP_CALL, 13'h0300);
        err_seen |= err;
        n_checks++;
        if (pc_addr !== 13'h0300 || depth !== 3'd2) begin
            $display("FAIL call2: got pc=%h depth=%0d expected 0300/2", pc_addr, depth); n_errors++;
        end
        step(1'b1, OP_RET, 13'h0000);
        err_seen |= err;
        n_checks++;
        if (pc_addr !== 13'h0201 || depth !== 3'd1) begin
            $display("FAIL ret1: got pc=%h depth=%0d expected 0201/1", pc_addr, depth); n_errors++;
        end
        step(1'b1, OP_RET, 13'h0000);
        err_seen |= err;
        n_checks++;
        if (pc_addr !== 13'h0101 || depth !== 3'd0 || stack_empty !== 1'b1) begin
            $display("FAIL ret2: got pc=%h depth=%0d empty=%b expected 0101/0/1", pc_addr, depth, stack_empty); n_errors++;
        end
        n_checks++;
        if (err_seen !== 1'b0) begin
            $display("FAIL nested_err: got %b expected 0", err_seen); n_errors++;
        end
    endtask

    task automatic test_overflow;
        logic [12:0] exp_ret [4];
        exp_ret = '{13'h0C01, 13'h0B01, 13'h0A01, 13'h0051};
        step(1'b1, OP_JUMP, 13'h0050);
        step(1'b1, OP_CALL, 13'h0A00);
        step(1'b1, OP_CALL, 13'h0B00);
        step(1'b1, OP_CALL, 13'h0C00);
        n_checks++;
        if (stack_full !== 1'b0 || depth !== 3'd3) begin
            $display("FAIL ovf_depth3: got full=%b depth=%0d expected 0/3", stack_full, depth); n_errors++;
        end
        step(1'b1, OP_CALL, 13'h0D00);
        n_checks++;
        if (stack_full !== 1'b1 || stack_empty !== 1'b0 || depth !== 3'd4 || pc_addr !== 13'h0D00) begin
            $display("FAIL ovf_full: got full=%b empty=%b depth=%0d pc=%h expected 1/0/4/0D00", stack_full, stack_empty, depth, pc_addr); n_errors++;
        end
        step(1'b1, OP_CALL, 13'h0E00);
        n_checks++;
        if (err !== 1'b1 || pc_addr !== 13'h0D00 || depth !== 3'd4) begin
            $display("FAIL ovf_err: got err=%b pc=%h depth=%0d expected 1/0D00/4", err, pc_addr, depth); n_errors++;
        end
        step(1'b0, OP_CALL, 13'h0E00);
        n_checks++;
        if (err !== 1'b0 || pc_addr !== 13'h0D00) begin
            $display("FAIL ovf_pulse: got err=%b pc=%h expected 0/0D00", err, pc_addr); n_errors++;
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, OP_RET, 13'h0000);
            n_checks++;
            if (pc_addr !== exp_ret[i] || depth !== 3'(3 - i) || err !== 1'b0) begin
                $display("FAIL ovf_ret%0d: got pc=%h depth=%0d err=%b expected %h/%0d/0", i, pc_addr, depth, err, exp_ret[i], 3 - i); n_errors++;
            end
        end
    endtask

    task automatic test_underflow;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, OP_RET, 13'h0000);
            n_checks++;
            if (err !== 1'b1 || pc_addr !== 13'h0051 || depth !== 3'd0) begin
                $display("FAIL udf_ret%0d: got err=%b pc=%h depth=%0d expected 1/0051/0", i, err, pc_addr, depth); n_errors++;
            end
        end
        step(1'b1, OP_INC, 13'h0000);
        n_checks++;
        if (err !== 1'b0 || pc_addr !== 13'h0052) begin
            $display("FAIL udf_inc: got err=%b pc=%h expected 0/0052", err, pc_addr); n_errors++;
        end
    endtask

    task automatic test_enable_reserved;
        step(1'b1, OP_CALL, 13'h0300);
        en = 1'b1; op = OP_JUMP; target = 13'h0777;
        #2;
        n_checks++;
        if (pc_addr !== 13'h0300) begin
            $display("FAIL no_comb_path: got %h expected %h", pc_addr, 13'h0300); n_errors++;
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, OP_JUMP, 13'h0555);
            n_checks++;
            if (pc_addr !== 13'h0300 || depth !== 3'd1 || err !== 1'b0) begin
                $display("FAIL en_hold%0d: got pc=%h depth=%0d err=%b expected 0300/1/0", i, pc_addr, depth, err); n_errors++;
            end
        end
        step(1'b1, OP_RSV7, 13'h0555);
        n_checks++;
        if (pc_addr !== 13'h0300 || depth !== 3'd1 || err !== 1'b0) begin
            $display("FAIL rsv7: got pc=%h depth=%0d err=%b expected 0300/1/0", pc_addr, depth, err); n_errors++;
        end
        step(1'b1, OP_RSV5, 13'h0555);
        n_checks++;
        if (pc_addr !== 13'h0300 || depth !== 3'd1 || err !== 1'b0) begin
            $display("FAIL rsv5: got pc=%h depth=%0d err=%b expected 0300/1/0", pc_addr, depth, err); n_errors++;
        end
        step(1'b1, OP_RET, 13'h0000);
        n_checks++;
        if (pc_addr !== 13'h0053 || depth !== 3'd0) begin
            $display("FAIL rsv_ret: got pc=%h depth=%0d expected 0053/0", pc_addr, depth); n_errors++;
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; op = OP_INC; target = '0;
        @(negedge clk);
        test_reset();
        test_wrap();
        test_nested_calls();
        test_overflow();
        test_underflow();
        test_enable_reserved();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
